// File: rtl/maze_stream_driver.sv
`default_nettype none
// ============================================================================
// Module      : maze_stream_driver
// Description : Transmit side and self-test checker for the maze solver.
//               Holds a 15x15 maze image written through a config port,
//               streams it row-major as 225 serial bits on start, then
//               receives the solver's path and checks that it is legal.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   cfg_we_i/row_i/col_i/bit_i write one maze cell (IDLE only, 1 = wall)
//   start_i                    one-cycle pulse that begins a run
//   maze_o, in_valid_o         serial maze stream to the solver
//   out_valid_i, maze_not_valid_i, out_x_i, out_y_i   solver response
//   busy_o                     high in every state except IDLE
//   done_o                     one-cycle pulse when the result is final
//   pass_o, no_path_o, path_len_o, err_code_o   result, held until next start
// ============================================================================
module maze_stream_driver #(
  parameter int TIMEOUT  = 4096,
  parameter int PATH_MAX = 169
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we_i,
  input  logic [3:0] cfg_row_i,
  input  logic [3:0] cfg_col_i,
  input  logic       cfg_bit_i,
  input  logic       start_i,
  output logic       maze_o,
  output logic       in_valid_o,
  input  logic       out_valid_i,
  input  logic       maze_not_valid_i,
  input  logic [3:0] out_x_i,
  input  logic [3:0] out_y_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic       no_path_o,
  output logic [7:0] path_len_o,
  output logic [2:0] err_code_o
);

  localparam int                CELLS     = 225;
  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [7:0]        LAST_BEAT = 8'd224;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_TIMEOUT = 3'd1;
  localparam logic [2:0] E_FIRST   = 3'd2;
  localparam logic [2:0] E_STEP    = 3'd3;
  localparam logic [2:0] E_WALL    = 3'd4;
  localparam logic [2:0] E_LAST    = 3'd5;
  localparam logic [2:0] E_LONG    = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND   = 3'd1,
    WAIT   = 3'd2,
    RECV   = 3'd3,
    REPORT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CELLS-1:0]   grid_q, grid_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [3:0]         prev_x_q, prev_x_d;
  logic [3:0]         prev_y_q, prev_y_d;
  logic               pass_q, pass_d;
  logic               no_path_q, no_path_d;
  logic [7:0]         len_q, len_d;
  logic [2:0]         err_q, err_d;

  // Row-major cell index; at most 15*15+15 = 240, so 8 bits suffice.
  function automatic logic [7:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
    return ({4'd0, row} * 8'd15) + {4'd0, col};
  endfunction

  // Per-coordinate legality checks on the current solver output.
  logic [7:0] len_inc;
  logic       in_range, on_wall, x_adj, y_adj, step_ok, take_elem;
  logic [2:0] elem_err;

  assign len_inc  = (len_q == 8'hFF) ? len_q : len_q + 8'd1;
  assign in_range = (out_x_i <= 4'd14) && (out_y_i <= 4'd14);
  assign on_wall  = !in_range || grid_q[cell_idx(out_y_i, out_x_i)];
  // Widened by one bit so that 15+1 cannot wrap onto 0.
  assign x_adj    = ({1'b0, out_x_i} == {1'b0, prev_x_q} + 5'd1) ||
                    ({1'b0, prev_x_q} == {1'b0, out_x_i} + 5'd1);
  assign y_adj    = ({1'b0, out_y_i} == {1'b0, prev_y_q} + 5'd1) ||
                    ({1'b0, prev_y_q} == {1'b0, out_y_i} + 5'd1);
  assign step_ok  = ((out_x_i == prev_x_q) && y_adj) || ((out_y_i == prev_y_q) && x_adj);

  always_comb begin
    elem_err = E_NONE;
    // The coordinate seen in WAIT is path element 0; it has no predecessor.
    if (state_q == WAIT) begin
      if ((out_x_i != 4'd13) || (out_y_i != 4'd13)) elem_err = E_FIRST;
    end else if (!step_ok) begin
      elem_err = E_STEP;
    end
    if (elem_err == E_NONE) begin
      if (on_wall)                          elem_err = E_WALL;
      else if (int'(len_inc) > PATH_MAX)    elem_err = E_LONG;
    end
  end

  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    prev_x_d  = prev_x_q;
    prev_y_d  = prev_y_q;
    pass_d    = pass_q;
    no_path_d = no_path_q;
    len_d     = len_q;
    err_d     = err_q;
    take_elem = 1'b0;

    case (state_q)
      IDLE: begin
        // The write lands on the same edge as start, so the run sees it.
        if (cfg_we_i && (cfg_row_i <= 4'd14) && (cfg_col_i <= 4'd14))
          grid_d[cell_idx(cfg_row_i, cfg_col_i)] = cfg_bit_i;
        if (start_i) begin
          state_d   = SEND;
          cnt_d     = 8'd0;
          pass_d    = 1'b0;
          no_path_d = 1'b0;
          len_d     = 8'd0;
          err_d     = E_NONE;
        end
      end
      SEND: begin
        if (cnt_q == LAST_BEAT) begin
          state_d = WAIT;
          wait_d  = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT: begin
        if (out_valid_i) begin
          if (maze_not_valid_i) begin
            no_path_d = 1'b1;
            len_d     = 8'd0;
            state_d   = REPORT;
          end else begin
            take_elem = 1'b1;
            state_d   = RECV;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_d   = E_TIMEOUT;
          state_d = REPORT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RECV: begin
        if (out_valid_i) begin
          if (maze_not_valid_i) begin
            if (err_q == E_NONE) err_d = E_FIRST;
            state_d = REPORT;
          end else begin
            take_elem = 1'b1;
          end
        end else begin
          if ((err_q == E_NONE) && !((prev_x_q == 4'd1) && (prev_y_q == 4'd1)))
            err_d = E_LAST;
          state_d = REPORT;
        end
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (take_elem) begin
      len_d    = len_inc;
      prev_x_d = out_x_i;
      prev_y_d = out_y_i;
      if (err_q == E_NONE) err_d = elem_err;
    end

    // Resolve pass on the way into REPORT so it is valid alongside done.
    if ((state_q != REPORT) && (state_d == REPORT)) pass_d = (err_d == E_NONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grid_q    <= '0;
      cnt_q     <= 8'd0;
      wait_q    <= '0;
      prev_x_q  <= 4'd0;
      prev_y_q  <= 4'd0;
      pass_q    <= 1'b0;
      no_path_q <= 1'b0;
      len_q     <= 8'd0;
      err_q     <= E_NONE;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      prev_x_q  <= prev_x_d;
      prev_y_q  <= prev_y_d;
      pass_q    <= pass_d;
      no_path_q <= no_path_d;
      len_q     <= len_d;
      err_q     <= err_d;
    end
  end

  assign in_valid_o = (state_q == SEND);
  assign maze_o     = (state_q == SEND) && grid_q[cnt_q];
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == REPORT);
  assign pass_o     = pass_q;
  assign no_path_o  = no_path_q;
  assign path_len_o = len_q;
  assign err_code_o = err_q;

endmodule
`default_nettype wire
